// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: 3-input round-robin arbiter feeding a registered output.
//
// Three requesters compete for a single output register. The grant goes to
// the first valid requester in rotating priority order, starting at ptr.
// Data is routed through a two-stage 2:1 mux tree. The output register is a
// one-deep skid-free stage: it accepts a new word when it is empty, or when
// it is being drained in the same cycle.
//
// Optional feature, enabled by defining MUX_ARB_LOCK_EN:
//   Adds port in_lock. A requester that transfers with its lock bit set keeps
//   the grant for as long as its in_valid stays high. While it holds the lock
//   the priority pointer does not advance. The lock is released by a transfer
//   with the lock bit clear, or by the owner dropping in_valid.
//   Without the macro there is no in_lock port, and arbitration re-runs after
//   every transfer.

module mux_rr_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [2:0]        in_valid,
`ifdef MUX_ARB_LOCK_EN
  input  logic [2:0]        in_lock,
`endif
  output logic [2:0]        in_ready,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        sel,
  output logic [1:0]        out_src
);

  // Output-register occupancy states. out_valid is decoded from these.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Next requester index in the ring 0 -> 1 -> 2 -> 0.
  // The code 3 is never stored, but it is mapped back to 0 for safety.
  function automatic logic [1:0] inc_mod3(input logic [1:0] idx);
    logic [1:0] res;
    case (idx)
      2'd0:    res = 2'd1;
      2'd1:    res = 2'd2;
      2'd2:    res = 2'd0;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

  // Bit of a 3-bit request vector selected by a 2-bit requester index.
  // An out-of-range index reads as "not set".
  function automatic logic bit_at(input logic [2:0] vec, input logic [1:0] idx);
    logic res;
    case (idx)
      2'd0:    res = vec[0];
      2'd1:    res = vec[1];
      2'd2:    res = vec[2];
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // One-hot encoding of a requester index.
  // An out-of-range index yields no bit set.
  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] res;
    case (idx)
      2'd0:    res = 3'b001;
      2'd1:    res = 3'b010;
      2'd2:    res = 3'b100;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  // State
  logic [0:0]        state_r;
  logic [0:0]        state_nxt_s;
  logic [DATA_W-1:0] out_r;
  logic [1:0]        out_src_r;
  logic [1:0]        ptr_r;
  logic [1:0]        ptr_nxt_s;

  // Arbitration
  logic [1:0]        cand0_s;
  logic [1:0]        cand1_s;
  logic [1:0]        cand2_s;
  logic              rr_vld_s;
  logic [1:0]        rr_idx_s;
  logic              grant_vld_s;
  logic [1:0]        grant_idx_s;
  logic              lock_hold_s;
  logic              lock_req_s;

  // Handshake and datapath
  logic              free_s;
  logic              xfer_s;
  logic [2:0]        in_ready_s;
  logic [1:0]        sel_s;
  logic [DATA_W-1:0] stage1_s;
  logic [DATA_W-1:0] data_sel_s;

  // Candidate order for this cycle: ptr first, then the two that follow it.
  assign cand0_s = ptr_r;
  assign cand1_s = inc_mod3(cand0_s);
  assign cand2_s = inc_mod3(cand1_s);

  // Round-robin pick: the first valid candidate in priority order.
  always_comb begin
    rr_vld_s = 1'b0;
    rr_idx_s = 2'd0;
    if (bit_at(in_valid, cand0_s)) begin
      rr_vld_s = 1'b1;
      rr_idx_s = cand0_s;
    end else if (bit_at(in_valid, cand1_s)) begin
      rr_vld_s = 1'b1;
      rr_idx_s = cand1_s;
    end else if (bit_at(in_valid, cand2_s)) begin
      rr_vld_s = 1'b1;
      rr_idx_s = cand2_s;
    end else begin
      rr_vld_s = 1'b0;
      rr_idx_s = 2'd0;
    end
  end

`ifdef MUX_ARB_LOCK_EN
  logic       lock_r;
  logic [1:0] lock_idx_r;

  // The lock owner keeps the grant only while it is still requesting.
  assign lock_hold_s = lock_r & bit_at(in_valid, lock_idx_r);
  assign lock_req_s  = bit_at(in_lock, grant_idx_s);

  // Lock tracking: latch the owner on a locking transfer.
  // Release on a non-locking transfer, or when the owner withdraws.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_r     <= 1'b0;
      lock_idx_r <= 2'd0;
    end else if (xfer_s) begin
      lock_r     <= lock_req_s;
      lock_idx_r <= grant_idx_s;
    end else if (lock_r && !bit_at(in_valid, lock_idx_r)) begin
      lock_r     <= 1'b0;
      lock_idx_r <= lock_idx_r;
    end else begin
      lock_r     <= lock_r;
      lock_idx_r <= lock_idx_r;
    end
  end

  // A held lock overrides the round-robin pick.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = 2'd0;
    if (lock_hold_s) begin
      grant_vld_s = 1'b1;
      grant_idx_s = lock_idx_r;
    end else begin
      grant_vld_s = rr_vld_s;
      grant_idx_s = rr_idx_s;
    end
  end
`else
  assign lock_hold_s = 1'b0;
  assign lock_req_s  = 1'b0;

  // Without locking, the grant is simply the round-robin pick.
  always_comb begin
    grant_vld_s = rr_vld_s;
    grant_idx_s = rr_idx_s;
  end
`endif

  // The register can take a word when it is empty, or is being drained now.
  assign free_s = (state_r == ST_EMPTY) | out_ready;

  // Ready goes only to the granted requester.
  // It is suppressed while the register is blocked, or while reset is asserted.
  always_comb begin
    in_ready_s = 3'b000;
    if (rst_n && grant_vld_s && free_s) begin
      in_ready_s = onehot3(grant_idx_s);
    end else begin
      in_ready_s = 3'b000;
    end
  end

  // A grant implies the granted requester is valid, so ready alone marks a transfer.
  assign xfer_s = |(in_ready_s & in_valid);

  // Mux select follows the grant; with no grant it parks at in0.
  assign sel_s = grant_vld_s ? grant_idx_s : 2'b00;

  // Two-stage 3:1 select: sel[0] chooses in0/in1, then sel[1] chooses that or in2.
  assign stage1_s   = sel_s[0] ? in1 : in0;
  assign data_sel_s = sel_s[1] ? in2 : stage1_s;

  // Occupancy next-state: fill on transfer, drain when consumed without refill.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (xfer_s) begin
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (!out_ready) begin
          state_nxt_s = ST_FULL;
        end else if (xfer_s) begin
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // Pointer moves past the winner on a transfer.
  // It holds on idle cycles and while a lock is being taken or kept.
  always_comb begin
    ptr_nxt_s = ptr_r;
    if (xfer_s && !lock_req_s) begin
      ptr_nxt_s = inc_mod3(grant_idx_s);
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Occupancy state and priority pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
      ptr_r   <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
    end
  end

  // Output word and source index: load on transfer, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r     <= {DATA_W{1'b0}};
      out_src_r <= 2'b00;
    end else if (xfer_s) begin
      out_r     <= data_sel_s;
      out_src_r <= grant_idx_s;
    end else begin
      out_r     <= out_r;
      out_src_r <= out_src_r;
    end
  end

  assign out       = out_r;
  assign out_src   = out_src_r;
  assign out_valid = (state_r == ST_FULL);
  assign in_ready  = in_ready_s;
  assign sel       = sel_s;

endmodule
